// File: rtl/reg_bank.sv
// Parameterised register bank: RW registers, W1C STATUS, saturating write counter.
// One access per cycle, registered read data with single-cycle latency.
module reg_bank #(
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 4,
    parameter int ADDR_W   = 3
) (
    input  logic                       CLK,
    input  logic                       RST_N,
    input  logic                       WRITE,
    input  logic                       READ,
    input  logic [ADDR_W-1:0]          ADDR,
    input  logic [DATA_W-1:0]          WRITE_DATA,
    input  logic [DATA_W-1:0]          EVENT,
    output logic [DATA_W-1:0]          READ_DATA,
    output logic                       READ_VALID,
    output logic                       ERR,
    output logic [NUM_REGS*DATA_W-1:0] REG_OUT
);

    if ((2 ** ADDR_W) < (NUM_REGS + 2)) begin : g_addr_chk
        $error("reg_bank: ADDR_W too small for NUM_REGS+2 addresses");
    end

    localparam logic [ADDR_W-1:0] A_STAT = ADDR_W'(NUM_REGS);
    localparam logic [ADDR_W-1:0] A_WCNT = ADDR_W'(NUM_REGS + 1);

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [DATA_W-1:0] status;
    logic [DATA_W-1:0] wcount;
    logic [DATA_W-1:0] rd_mux;
    logic [DATA_W-1:0] clr_mask;
    logic              is_rw;
    logic              is_stat;
    logic              is_wcnt;
    logic              is_oor;

    assign is_rw   = ADDR < A_STAT;
    assign is_stat = ADDR == A_STAT;
    assign is_wcnt = ADDR == A_WCNT;
    assign is_oor  = !(is_rw || is_stat || is_wcnt);

    assign clr_mask = (WRITE && is_stat) ? WRITE_DATA : '0;

    always_comb begin
        rd_mux = '0;
        unique case (1'b1)
            is_rw: begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (ADDR == ADDR_W'(i)) begin
                        rd_mux = regs[i];
                    end
                end
            end
            is_stat: rd_mux = status;
            is_wcnt: rd_mux = wcount;
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (WRITE) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (ADDR == ADDR_W'(i)) begin
                    regs[i] <= WRITE_DATA;
                end
            end
        end
    end

    // EVENT is OR'd in after the clear so a colliding event wins.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            status <= '0;
        end else begin
            status <= (status & ~clr_mask) | EVENT;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wcount <= '0;
        end else if (WRITE && is_wcnt) begin
            wcount <= '0;
        end else if (WRITE && (is_rw || is_stat) && wcount != '1) begin
            wcount <= wcount + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            READ_DATA  <= '0;
            READ_VALID <= 1'b0;
            ERR        <= 1'b0;
        end else begin
            READ_VALID <= READ;
            ERR        <= (READ || WRITE) && is_oor;
            if (READ) begin
                READ_DATA <= rd_mux;
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
        assign REG_OUT[g*DATA_W +: DATA_W] = regs[g];
    end

endmodule

// File: tb/tb_reg_bank.sv
// Directed testbench for reg_bank with default parameters.
// Inputs change after the rising edge; outputs are sampled 1 time unit later.
module tb_reg_bank;

    logic        CLK;
    logic        RST_N;
    logic        WRITE;
    logic        READ;
    logic [2:0]  ADDR;
    logic [7:0]  WRITE_DATA;
    logic [7:0]  EVENT;
    logic [7:0]  READ_DATA;
    logic        READ_VALID;
    logic        ERR;
    logic [31:0] REG_OUT;

    int n_vec;
    int n_err;

    reg_bank dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .WRITE      (WRITE),
        .READ       (READ),
        .ADDR       (ADDR),
        .WRITE_DATA (WRITE_DATA),
        .EVENT      (EVENT),
        .READ_DATA  (READ_DATA),
        .READ_VALID (READ_VALID),
        .ERR        (ERR),
        .REG_OUT    (REG_OUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // One clocked access; outputs are valid for it on return.
    task automatic acc(input logic w, input logic r, input logic [2:0] a,
                       input logic [7:0] wd, input logic [7:0] ev);
        WRITE      = w;
        READ       = r;
        ADDR       = a;
        WRITE_DATA = wd;
        EVENT      = ev;
        @(posedge CLK);
        #1;
        WRITE = 1'b0;
        READ  = 1'b0;
        EVENT = '0;
    endtask

    task automatic rd(input logic [2:0] a, input logic [7:0] exp,
                      input string tag);
        acc(1'b0, 1'b1, a, 8'h00, 8'h00);
        chk({tag, "_vld"}, {31'd0, READ_VALID}, 32'd1);
        chk(tag, {24'd0, READ_DATA}, {24'd0, exp});
    endtask

    initial begin
        n_vec      = 0;
        n_err      = 0;
        RST_N      = 1'b0;
        WRITE      = 1'b0;
        READ       = 1'b0;
        ADDR       = '0;
        WRITE_DATA = '0;
        EVENT      = '0;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_rdata", {24'd0, READ_DATA}, 32'd0);
        chk("rst_rvld", {31'd0, READ_VALID}, 32'd0);
        chk("rst_err", {31'd0, ERR}, 32'd0);
        chk("rst_regout", REG_OUT, 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        @(posedge CLK);
        #1;

        // basic write then read
        acc(1'b1, 1'b0, 3'd2, 8'hA5, 8'h00);
        chk("w2_regout", {24'd0, REG_OUT[23:16]}, 32'hA5);
        chk("w2_err", {31'd0, ERR}, 32'd0);
        rd(3'd2, 8'hA5, "r2");
        acc(1'b0, 1'b0, 3'd0, 8'h00, 8'h00);
        chk("idle_vld", {31'd0, READ_VALID}, 32'd0);
        chk("idle_hold", {24'd0, READ_DATA}, 32'hA5);
        rd(3'd5, 8'h01, "wcnt1");

        // same-cycle read/write returns old value
        acc(1'b1, 1'b0, 3'd1, 8'h11, 8'h00);
        acc(1'b1, 1'b1, 3'd1, 8'h3C, 8'h00);
        chk("rw_old", {24'd0, READ_DATA}, 32'h11);
        rd(3'd1, 8'h3C, "rw_new");

        // STATUS: event priority over clear, then full clear
        acc(1'b0, 1'b0, 3'd0, 8'h00, 8'h81);
        acc(1'b1, 1'b0, 3'd4, 8'h01, 8'h01);
        rd(3'd4, 8'h81, "stat_81");
        acc(1'b1, 1'b0, 3'd4, 8'h81, 8'h00);
        rd(3'd4, 8'h00, "stat_00");
        rd(3'd5, 8'h05, "wcnt5");

        // counter clear, saturation, clear again
        acc(1'b1, 1'b0, 3'd5, 8'hFF, 8'h00);
        rd(3'd5, 8'h00, "wcnt_clr");
        for (int i = 0; i < 260; i++) begin
            acc(1'b1, 1'b0, 3'd0, 8'(i), 8'h00);
        end
        rd(3'd5, 8'hFF, "wcnt_sat");
        rd(3'd0, 8'h03, "r0_last");
        acc(1'b1, 1'b0, 3'd5, 8'h00, 8'h00);
        rd(3'd5, 8'h00, "wcnt_clr2");

        // out-of-range accesses
        acc(1'b1, 1'b0, 3'd7, 8'h55, 8'h00);
        chk("oor_w_err", {31'd0, ERR}, 32'd1);
        acc(1'b0, 1'b0, 3'd0, 8'h00, 8'h00);
        chk("oor_err_pulse", {31'd0, ERR}, 32'd0);
        rd(3'd7, 8'h00, "oor_r");
        chk("oor_r_err", {31'd0, ERR}, 32'd1);
        chk("oor_regout", REG_OUT, 32'h00A53C03);
        rd(3'd5, 8'h00, "oor_wcnt");
        rd(3'd6, 8'h00, "oor6");
        chk("oor6_err", {31'd0, ERR}, 32'd1);

        // reset in the middle of a read
        acc(1'b0, 1'b1, 3'd2, 8'h00, 8'h00);
        chk("pre_rst_vld", {31'd0, READ_VALID}, 32'd1);
        READ = 1'b1;
        ADDR = 3'd2;
        #2;
        RST_N = 1'b0;
        #1;
        chk("mid_rst_vld", {31'd0, READ_VALID}, 32'd0);
        chk("mid_rst_rdata", {24'd0, READ_DATA}, 32'd0);
        chk("mid_rst_regout", REG_OUT, 32'd0);
        WRITE      = 1'b1;
        ADDR       = 3'd0;
        WRITE_DATA = 8'hFF;
        EVENT      = 8'hFF;
        @(posedge CLK);
        @(negedge CLK);
        WRITE = 1'b0;
        READ  = 1'b0;
        EVENT = '0;
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
        chk("post_rst_vld", {31'd0, READ_VALID}, 32'd0);
        chk("post_rst_regout", REG_OUT, 32'd0);
        rd(3'd4, 8'h00, "post_rst_stat");
        rd(3'd5, 8'h00, "post_rst_wcnt");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
